// File: rtl/hx711_reader.sv
// hx711_reader: serial reader for the HX711 load-cell ADC.
// Generates PD_SCK, shifts in the 24-bit two's-complement result MSB-first,
// and presents a sign-extended sample with a one-cycle valid strobe.
// Supports runtime gain/channel selection (25/26/27 pulses), power-down,
// a saturation flag and a wrapping sample counter.
//
// Ports:
//   clk_50      system clock
//   rst_n       asynchronous active-low reset
//   dout        HX711 DOUT (asynchronous, synchronised internally)
//   pd_sck      HX711 PD_SCK
//   mode        gain for the next conversion (0=A/128, 1=B/32, 2=A/64, 3->0)
//   pd_req      power-down request (level)
//   data        last sample, sign-extended to OUT_W
//   data_valid  one-cycle strobe when data updates
//   data_mode   gain/channel that produced data
//   data_sat    raw sample was at positive or negative full scale
//   busy        high while shifting or latching
//   sample_cnt  completed sample count, wraps
module hx711_reader #(
   parameter int unsigned HALF_PERIOD = 32,
   parameter int unsigned OUT_W       = 24,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk_50,
   input  logic             rst_n,
   input  logic             dout,
   output logic             pd_sck,
   input  logic [1:0]       mode,
   input  logic             pd_req,
   output logic [OUT_W-1:0] data,
   output logic             data_valid,
   output logic [1:0]       data_mode,
   output logic             data_sat,
   output logic             busy,
   output logic [CNT_W-1:0] sample_cnt
);

   localparam int unsigned RAW_W   = 24;
   localparam int unsigned PH_W    = $clog2(HALF_PERIOD);
   localparam int unsigned PULSE_W = 5;

   localparam logic [PH_W-1:0]    PH_LAST      = PH_W'(HALF_PERIOD - 1);
   localparam logic [PULSE_W-1:0] SHIFT_PULSES = PULSE_W'(RAW_W);

   typedef enum logic [2:0] {
      WAIT_HI,
      IDLE,
      SHIFT,
      LATCH,
      PWRDN
   } state_t;

   state_t               state, state_d;
   logic                 dout_meta, dout_s;
   logic [1:0]           mode_eff;
   logic [PH_W-1:0]      ph_cnt, ph_cnt_d;
   logic [PULSE_W-1:0]   pulse_cnt, pulse_cnt_d;
   logic [PULSE_W-1:0]   pulse_last, pulse_last_d;
   logic [1:0]           mode_q, mode_q_d;
   logic [1:0]           prev_mode, prev_mode_d;
   logic [RAW_W-1:0]     shreg, shreg_d;
   logic                 sck_d, busy_d, valid_d, sat_d;
   logic [OUT_W-1:0]     data_d;
   logic [1:0]           data_mode_d;
   logic [CNT_W-1:0]     cnt_d;

   // Mode 3 is reserved on the chip; treat it as A/128.
   assign mode_eff = (mode == 2'd3) ? 2'd0 : mode;

   // Two-flop synchroniser for the asynchronous DOUT pin.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         dout_meta <= 1'b0;
         dout_s    <= 1'b0;
      end else begin
         dout_meta <= dout;
         dout_s    <= dout_meta;
      end
   end

   // State register.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) state <= WAIT_HI;
      else        state <= state_d;
   end

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d      = state;
      ph_cnt_d     = ph_cnt;
      pulse_cnt_d  = pulse_cnt;
      pulse_last_d = pulse_last;
      mode_q_d     = mode_q;
      prev_mode_d  = prev_mode;
      shreg_d      = shreg;
      sck_d        = 1'b0;
      busy_d       = 1'b0;
      valid_d      = 1'b0;
      data_d       = data;
      data_mode_d  = data_mode;
      sat_d        = data_sat;
      cnt_d        = sample_cnt;

      case (state)
         // Wait for DOUT to go high so the stale low after a read is not reused.
         WAIT_HI: begin
            if (pd_req)      state_d = PWRDN;
            else if (dout_s) state_d = IDLE;
         end
         IDLE: begin
            if (pd_req) begin
               state_d = PWRDN;
            end else if (!dout_s) begin
               mode_q_d     = mode_eff;
               pulse_last_d = SHIFT_PULSES + PULSE_W'(mode_eff);
               ph_cnt_d     = '0;
               pulse_cnt_d  = '0;
               state_d      = SHIFT;
            end
         end
         // Each pulse: HALF_PERIOD low then HALF_PERIOD high; sample at end of high.
         SHIFT: begin
            sck_d = pd_sck;
            if (ph_cnt == PH_LAST) begin
               ph_cnt_d = '0;
               if (!pd_sck) begin
                  sck_d = 1'b1;
               end else begin
                  sck_d = 1'b0;
                  if (pulse_cnt < SHIFT_PULSES)
                     shreg_d = {shreg[RAW_W-2:0], dout_s};
                  pulse_cnt_d = pulse_cnt + PULSE_W'(1);
                  if (pulse_cnt == pulse_last) state_d = LATCH;
               end
            end else begin
               ph_cnt_d = ph_cnt + PH_W'(1);
            end
         end
         // The chip applies a gain to the conversion after the one that set it.
         LATCH: begin
            data_d      = OUT_W'($signed(shreg));
            sat_d       = (shreg == 24'h7FFFFF) || (shreg == 24'h800000);
            data_mode_d = prev_mode;
            prev_mode_d = mode_q;
            valid_d     = 1'b1;
            cnt_d       = sample_cnt + CNT_W'(1);
            state_d     = WAIT_HI;
         end
         // Leaving power-down resets the chip to A/128.
         PWRDN: begin
            if (!pd_req) begin
               prev_mode_d = 2'd0;
               state_d     = WAIT_HI;
            end
         end
         default: state_d = WAIT_HI;
      endcase

      if (state_d == PWRDN) sck_d = 1'b1;
      busy_d = (state_d == SHIFT) || (state_d == LATCH);
   end

   // Datapath and output registers.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         ph_cnt     <= '0;
         pulse_cnt  <= '0;
         pulse_last <= '0;
         mode_q     <= 2'd0;
         prev_mode  <= 2'd0;
         shreg      <= '0;
         pd_sck     <= 1'b0;
         busy       <= 1'b0;
         data_valid <= 1'b0;
         data       <= '0;
         data_mode  <= 2'd0;
         data_sat   <= 1'b0;
         sample_cnt <= '0;
      end else begin
         ph_cnt     <= ph_cnt_d;
         pulse_cnt  <= pulse_cnt_d;
         pulse_last <= pulse_last_d;
         mode_q     <= mode_q_d;
         prev_mode  <= prev_mode_d;
         shreg      <= shreg_d;
         pd_sck     <= sck_d;
         busy       <= busy_d;
         data_valid <= valid_d;
         data       <= data_d;
         data_mode  <= data_mode_d;
         data_sat   <= sat_d;
         sample_cnt <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hx711_reader.sv
// tb_hx711_reader: randomized bench for hx711_reader with an HX711 chip model
// and a cycle-level expectation model derived from conversion timing rules.
module tb_hx711_reader;

   localparam int HP = 32;
   localparam int OW = 32;
   localparam int CW = 4;

   logic          clk_50 = 1'b0;
   logic          rst_n  = 1'b0;
   logic          dout   = 1'b1;
   logic          pd_req = 1'b0;
   logic [1:0]    mode   = 2'd0;
   logic          pd_sck, data_valid, data_sat, busy;
   logic [OW-1:0] data;
   logic [1:0]    data_mode;
   logic [CW-1:0] sample_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model state written by the stimulus process.
   bit          conv_on   = 1'b0;
   int          s_cyc     = 0;
   int          n_m       = 25;
   logic [31:0] pend_data = '0;
   logic [1:0]  pend_mode = 2'd0;
   logic        pend_sat  = 1'b0;
   int          gain_m    = 0;
   bit          pw_on     = 1'b0;
   int          pw_start  = 0;
   int          pw_end    = 0;
   int          last_pulses = 0;
   int          last_lat    = 0;

   // Expected held outputs, written by the compare process only.
   logic [31:0] exp_data = '0;
   logic [1:0]  exp_mode = 2'd0;
   logic        exp_sat  = 1'b0;
   int          exp_cnt  = 0;

   hx711_reader #(
      .HALF_PERIOD (HP),
      .OUT_W       (OW),
      .CNT_W       (CW)
   ) dut (
      .clk_50     (clk_50),
      .rst_n      (rst_n),
      .dout       (dout),
      .pd_sck     (pd_sck),
      .mode       (mode),
      .pd_req     (pd_req),
      .data       (data),
      .data_valid (data_valid),
      .data_mode  (data_mode),
      .data_sat   (data_sat),
      .busy       (busy),
      .sample_cnt (sample_cnt)
   );

   always #10 clk_50 = ~clk_50;
   always @(posedge clk_50) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Per-cycle compare: expectations from time since SHIFT entry.
   initial begin
      int k, t, per;
      logic e_sck, e_busy, e_valid;
      forever begin
         @(negedge clk_50);
         #5;
         k = cyc;
         t = k - s_cyc;
         per = 2 * n_m * HP;
         e_sck = 1'b0; e_busy = 1'b0; e_valid = 1'b0;
         if (!rst_n) begin
            exp_data = '0; exp_mode = 2'd0; exp_sat = 1'b0; exp_cnt = 0;
         end else begin
            if (conv_on && t >= 0) begin
               if (t < per) e_sck = ((t % (2 * HP)) >= HP);
               e_busy = (t <= per);
               if (t == per + 1) begin
                  e_valid  = 1'b1;
                  exp_data = pend_data;
                  exp_mode = pend_mode;
                  exp_sat  = pend_sat;
                  exp_cnt  = (exp_cnt + 1) % (1 << CW);
               end
            end
            if (pw_on && k >= pw_start && k <= pw_end) e_sck = 1'b1;
         end
         chk("pd_sck",     32'(pd_sck),     32'(e_sck));
         chk("busy",       32'(busy),       32'(e_busy));
         chk("data_valid", 32'(data_valid), 32'(e_valid));
         chk("data",       data,            exp_data);
         chk("data_mode",  32'(data_mode),  32'(exp_mode));
         chk("data_sat",   32'(data_sat),   32'(exp_sat));
         chk("sample_cnt", 32'(sample_cnt), 32'(exp_cnt));
      end
   end

   // One conversion: the chip model drops DOUT, then presents bits on SCK rises.
   task automatic convert(input logic [23:0] val, input logic [1:0] md, input logic [1:0] md_mid,
                          input bit pd_mid, input bit rst_mid, input int gap);
      int me, pulses, vcyc;
      logic prev;
      repeat (gap) @(negedge clk_50);
      me        = (md == 2'd3) ? 0 : int'(md);
      mode      = md;
      dout      = 1'b0;
      pend_data = {{8{val[23]}}, val};
      pend_mode = 2'(gain_m);
      pend_sat  = (val == 24'h7FFFFF) || (val == 24'h800000);
      gain_m    = me;
      n_m       = 25 + me;
      s_cyc     = cyc + 3;
      conv_on   = 1'b1;
      pulses = 0; vcyc = -1; prev = 1'b0;
      for (int i = 0; i < 2 * n_m * HP + 8; i++) begin
         @(negedge clk_50);
         if (cyc == s_cyc + 5) mode = md_mid;
         if (pd_mid && cyc == s_cyc + 100) begin
            pd_req   = 1'b1;
            pw_start = s_cyc + 2 * n_m * HP + 2;
            pw_end   = 32'h7FFFFFFF;
            pw_on    = 1'b1;
         end
         if (pd_sck && !prev && cyc < s_cyc + 2 * n_m * HP) begin
            pulses++;
            dout = (pulses <= 24) ? val[24 - pulses] : 1'b1;
         end
         prev = pd_sck;
         if (data_valid) vcyc = cyc;
         if (rst_mid && cyc == s_cyc + 19 * HP + 5) begin
            chk("pulse_at_reset", 32'(pulses), 32'd10);
            rst_n   = 1'b0;
            conv_on = 1'b0;
            gain_m  = 0;
            dout    = 1'b1;
            #1 chk("async_sck_drop", 32'(pd_sck), 32'd0);
            repeat (4) @(negedge clk_50);
            rst_n = 1'b1;
            return;
         end
      end
      last_pulses = pulses;
      last_lat    = vcyc - s_cyc;
      chk("pulse_count",   32'(pulses),   32'(n_m));
      chk("valid_latency", 32'(last_lat), 32'(2 * n_m * HP + 1));
   endtask

   initial begin
      logic [23:0] v;
      // Reset and idle with DOUT high.
      repeat (5) @(negedge clk_50);
      rst_n = 1'b1;
      repeat (100) @(negedge clk_50);
      chk("reset_data",   data,             32'h0);
      chk("reset_cnt",    32'(sample_cnt),  32'd0);
      chk("reset_sck",    32'(pd_sck),      32'd0);

      // Basic A/128 conversion.
      convert(24'h123456, 2'd0, 2'd0, 1'b0, 1'b0, 5);
      chk("basic_data",    data,            32'h00123456);
      chk("basic_latency", 32'(last_lat),   32'd1601);
      chk("basic_pulses",  32'(last_pulses), 32'd25);
      chk("basic_cnt",     32'(sample_cnt), 32'd1);
      chk("basic_mode",    32'(data_mode),  32'd0);

      // Sign extension and saturation.
      convert(24'hFFFFFE, 2'd0, 2'd0, 1'b0, 1'b0, 5);
      chk("neg_data", data, 32'hFFFFFFFE);
      chk("neg_sat",  32'(data_sat), 32'd0);
      convert(24'h7FFFFF, 2'd0, 2'd0, 1'b0, 1'b0, 7);
      chk("pos_full_data", data, 32'h007FFFFF);
      chk("pos_full_sat",  32'(data_sat), 32'd1);
      convert(24'h800000, 2'd0, 2'd0, 1'b0, 1'b0, 4);
      chk("neg_full_data", data, 32'hFF800000);
      chk("neg_full_sat",  32'(data_sat), 32'd1);

      // Gain selection with mid-conversion mode changes.
      convert(24'($urandom), 2'd1, 2'd3, 1'b0, 1'b0, 6);
      chk("gain_b_pulses", 32'(last_pulses), 32'd26);
      chk("gain_k_mode",   32'(data_mode),   32'd0);
      convert(24'($urandom), 2'd2, 2'd1, 1'b0, 1'b0, 6);
      chk("gain_a64_pulses", 32'(last_pulses), 32'd27);
      chk("gain_k1_mode",    32'(data_mode),   32'd1);
      convert(24'($urandom), 2'd0, 2'd2, 1'b0, 1'b0, 6);
      chk("gain_k2_mode", 32'(data_mode), 32'd2);

      // Power-down requested mid-conversion.
      convert(24'($urandom), 2'd3, 2'd2, 1'b1, 1'b0, 5);
      chk("pd_pulses", 32'(last_pulses), 32'd25);
      repeat (30) @(negedge clk_50);
      chk("pd_hold_high", 32'(pd_sck), 32'd1);
      pd_req = 1'b0; pw_end = cyc; gain_m = 0;
      repeat (3) @(negedge clk_50);
      chk("pd_release_low", 32'(pd_sck), 32'd0);
      convert(24'($urandom), 2'd2, 2'd2, 1'b0, 1'b0, 5);
      chk("pd_after_mode", 32'(data_mode), 32'd0);

      // Power-down requested while idle resets the gain to A/128.
      repeat (5) @(negedge clk_50);
      pd_req = 1'b1; pw_start = cyc + 1; pw_end = 32'h7FFFFFFF; pw_on = 1'b1;
      repeat (20) @(negedge clk_50);
      chk("idle_pd_high", 32'(pd_sck), 32'd1);
      pd_req = 1'b0; pw_end = cyc; gain_m = 0;
      convert(24'($urandom), 2'd1, 2'd0, 1'b0, 1'b0, 5);
      chk("idle_pd_mode", 32'(data_mode), 32'd0);

      // Reset mid-conversion, then random traffic through the counter wrap.
      convert(24'($urandom), 2'd0, 2'd0, 1'b0, 1'b1, 5);
      repeat (3) @(negedge clk_50);
      chk("rst_data", data, 32'h0);
      chk("rst_cnt",  32'(sample_cnt), 32'd0);
      for (int n = 1; n <= 18; n++) begin
         v = 24'($urandom);
         if (n % 7 == 3) v = 24'h7FFFFF;
         if (n % 7 == 5) v = 24'h800000;
         convert(v, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0, 1'b0,
                 int'($urandom_range(3, 20)));
         if (n == 15) chk("cnt_max",  32'(sample_cnt), 32'd15);
         if (n == 16) chk("cnt_wrap", 32'(sample_cnt), 32'd0);
      end
      repeat (10) @(negedge clk_50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
